// File: rtl/sipo_frame_pkg.sv
// Shared types and sizing helpers for the frame synchroniser.
// Holds the sync state enum, word/slot sizes and a counter-width helper.
package sipo_frame_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int WORD_W      = 16;
    localparam int SLOT_CYCLES = 16;

    // Bits needed to hold values 0..max_val.
    function automatic int cnt_w(input int max_val);
        int w;
        w = 1;
        while ((1 << w) <= max_val) w++;
        return w;
    endfunction

endpackage

// File: rtl/word_fifo2.sv
// Two-entry valid/ready buffer for captured payload words.
// Ports: push/push_data in, head/valid/pop_ready out side, sticky overflow.
module word_fifo2
    import sipo_frame_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [WORD_W-1:0] push_data,
    input  logic              pop_ready,
    output logic [WORD_W-1:0] head,
    output logic              valid,
    output logic              overflow
);

    logic [WORD_W-1:0] slot0;
    logic [WORD_W-1:0] slot1;
    logic [1:0]        count;
    logic              pop;

    assign valid = (count != 2'd0);
    assign pop   = valid && pop_ready;
    assign head  = valid ? slot0 : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            slot0    <= '0;
            slot1    <= '0;
            count    <= 2'd0;
            overflow <= 1'b0;
        end else if (pop && push) begin
            // Count is unchanged; the new word lands behind any survivor.
            if (count == 2'd2) begin
                slot0 <= slot1;
                slot1 <= push_data;
            end else begin
                slot0 <= push_data;
            end
        end else if (pop) begin
            slot0 <= slot1;
            count <= count - 2'd1;
        end else if (push) begin
            if (count == 2'd0) begin
                slot0 <= push_data;
                count <= 2'd1;
            end else if (count == 2'd1) begin
                slot1 <= push_data;
                count <= 2'd2;
            end else begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sipo_frame_sync.sv
// Frame synchroniser: hunts for SYNC_WORD, confirms, then captures payload.
// Ports: clk, reset, parallel_in, word_ready in; word_out/valid, locked, sync_err, overflow out.
module sipo_frame_sync
    import sipo_frame_pkg::*;
#(
    parameter logic [WORD_W-1:0] SYNC_WORD     = 16'hF628,
    parameter int                PAYLOAD_WORDS = 4,
    parameter int                CONFIRM       = 2,
    parameter int                MISS_LIMIT    = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WORD_W-1:0] parallel_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              locked,
    output logic              sync_err,
    output logic              overflow
);

    localparam int SL_W = $clog2(SLOT_CYCLES);
    localparam int WC_W = cnt_w(PAYLOAD_WORDS);
    localparam int CF_W = cnt_w(CONFIRM);
    localparam int MS_W = cnt_w(MISS_LIMIT);

    localparam logic [SL_W-1:0] SLOT_LAST = SL_W'(SLOT_CYCLES - 1);
    localparam logic [WC_W-1:0] WC_LAST   = WC_W'(PAYLOAD_WORDS);
    localparam logic [CF_W-1:0] CF_DONE   = CF_W'(CONFIRM);
    localparam logic [MS_W-1:0] MS_DONE   = MS_W'(MISS_LIMIT);

    state_t          state;
    logic [SL_W-1:0] slot_cnt;
    logic [WC_W-1:0] word_cnt;
    logic [CF_W-1:0] conf_cnt;
    logic [MS_W-1:0] miss_cnt;

    logic sync_hit;
    logic boundary;
    logic sync_slot;
    logic push;

    assign sync_hit  = (parallel_in == SYNC_WORD);
    assign boundary  = (state != HUNT) && (slot_cnt == SLOT_LAST);
    assign sync_slot = boundary && (word_cnt == WC_LAST);
    assign push      = (state == LOCKED) && boundary && !sync_slot;
    assign locked    = (state == LOCKED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= HUNT;
            slot_cnt <= '0;
            word_cnt <= '0;
            conf_cnt <= '0;
            miss_cnt <= '0;
            sync_err <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            // Slot timing free-runs; slot count is a power of two so it wraps.
            slot_cnt <= slot_cnt + 1'b1;
            if (boundary) begin
                word_cnt <= (word_cnt == WC_LAST) ? '0 : word_cnt + 1'b1;
            end
            unique case (state)
                HUNT: begin
                    if (sync_hit) begin
                        state    <= VERIFY;
                        slot_cnt <= '0;
                        word_cnt <= '0;
                        conf_cnt <= CF_W'(1);
                    end
                end
                VERIFY: begin
                    if (sync_slot) begin
                        if (sync_hit) begin
                            conf_cnt <= conf_cnt + 1'b1;
                            if (conf_cnt + 1'b1 == CF_DONE) begin
                                state    <= LOCKED;
                                miss_cnt <= '0;
                            end
                        end else begin
                            state <= HUNT;
                        end
                    end
                end
                LOCKED: begin
                    if (sync_slot) begin
                        if (sync_hit) begin
                            miss_cnt <= '0;
                        end else begin
                            sync_err <= 1'b1;
                            miss_cnt <= miss_cnt + 1'b1;
                            if (miss_cnt + 1'b1 == MS_DONE) state <= HUNT;
                        end
                    end
                end
                default: state <= HUNT;
            endcase
        end
    end

    word_fifo2 u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (parallel_in),
        .pop_ready (word_ready),
        .head      (word_out),
        .valid     (word_valid),
        .overflow  (overflow)
    );

endmodule
